// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the counter, its encoder and benches.
// Functions run at a fixed maximum width; callers zero-extend and truncate.
package gray_pkg;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int GRAY_MAX_WIDTH = 16;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin_to_gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray_to_bin(input logic [GRAY_MAX_WIDTH-1:0] g);
        logic [GRAY_MAX_WIDTH-1:0] b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bin_to_gray_enc.sv
// Combinational binary-to-Gray encoder; thin wrapper around the package function.
module bin_to_gray_enc
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin_to_gray(GRAY_MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a Gray code registered on the same edge as the count.
// Intended as a clock-domain-crossing pointer source.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_bin_s;
    logic [WIDTH-1:0] next_gray_s;
    logic             next_wrap_s;

    // Next binary value and wrap flag: load beats count beats hold.
    always_comb begin
        next_bin_s  = bin_r;
        next_wrap_s = 1'b0;
        if (load) begin
            next_bin_s  = load_bin;
            next_wrap_s = 1'b0;
        end else if (en) begin
            if (up_dn) begin
                next_bin_s  = bin_r + WIDTH'(1);
                next_wrap_s = (bin_r == ALL_ONES);
            end else begin
                next_bin_s  = bin_r - WIDTH'(1);
                next_wrap_s = (bin_r == ALL_ZERO);
            end
        end else begin
            next_bin_s  = bin_r;
            next_wrap_s = 1'b0;
        end
    end

    // Encode the next value so gray and bin land on the same edge with no skew.
    bin_to_gray_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bin  (next_bin_s),
        .gray (next_gray_s)
    );

    // Output registers; reset dominates everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_r  <= ALL_ZERO;
            gray_r <= ALL_ZERO;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= next_bin_s;
            gray_r <= next_gray_s;
            wrap_r <= next_wrap_s;
        end
    end

    assign bin  = bin_r;
    assign gray = gray_r;
    assign wrap = wrap_r;

endmodule
